pong_game_ctrl: RTL

Game-sequencing controller for the VGA pong design. It owns the ball and the two paddles and runs the match state machine: idle, serve, play, point and game over. It updates positions once per frame during vertical blanking, from the same `sx`/`sy` counters the renderer uses. Its registered position and score outputs feed the pixel-drawing logic, which is purely a consumer.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/pong_paddle.sv | 46 ++++
 rtl/pong_game_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong design: state encoding, default geometry
// and small arithmetic helpers used by the controller and the renderer.
package pong_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } state_e;

   localparam int unsigned DEF_XRES         = 640;
   localparam int unsigned DEF_YRES         = 480;
   localparam int unsigned DEF_YMAX         = 524;
   localparam int unsigned DEF_BALL_SIZE    = 8;
   localparam int unsigned DEF_BALL_SPD     = 2;
   localparam int unsigned DEF_PAD_H        = 48;
   localparam int unsigned DEF_PAD_W        = 8;
   localparam int unsigned DEF_PAD_X_L      = 16;
   localparam int unsigned DEF_PAD_X_R      = 616;
   localparam int unsigned DEF_PAD_SPD      = 4;
   localparam int unsigned DEF_SERVE_FRAMES = 60;
   localparam int unsigned DEF_POINT_FRAMES = 30;
   localparam int unsigned DEF_WIN_SCORE    = 9;

   // Score increment that sticks at the 4-bit ceiling.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hf) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: steps up or down once per enabled frame and stays inside the
// playfield. Both or neither button held leaves the paddle where it is.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int unsigned YRES    = DEF_YRES,
   parameter int unsigned PAD_H   = DEF_PAD_H,
   parameter int unsigned PAD_SPD = DEF_PAD_SPD
) (
   input  logic       clk_25,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       dn,
   output logic [9:0] y
);

   localparam logic [10:0] YLIM = 11'(YRES - PAD_H);
   localparam logic [10:0] STEP = 11'(PAD_SPD);
   localparam logic [9:0]  YRST = 10'((YRES - PAD_H) / 2);

   logic [10:0] y_wide;
   logic [9:0]  y_up;
   logic [9:0]  y_dn;

   // Candidate positions, computed in 11 bits so neither direction can wrap.
   always_comb begin
      y_wide = {1'b0, y};
      y_up   = (y_wide < STEP) ? 10'd0 : 10'(y_wide - STEP);
      y_dn   = (y_wide + STEP > YLIM) ? 10'(YLIM) : 10'(y_wide + STEP);
   end

   // Position register, updated only on enabled frame ticks.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         y <= YRST;
      end else if (en) begin
         if (up && !dn) begin
            y <= y_up;
         end else if (dn && !up) begin
            y <= y_dn;
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer for pong: owns the ball, the scores and the two paddles and
// steps them once per frame at the start of the last blanking line.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned XRES         = DEF_XRES,
   parameter int unsigned YRES         = DEF_YRES,
   parameter int unsigned YMAX         = DEF_YMAX,
   parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
   parameter int unsigned BALL_SPD     = DEF_BALL_SPD,
   parameter int unsigned PAD_H        = DEF_PAD_H,
   parameter int unsigned PAD_W        = DEF_PAD_W,
   parameter int unsigned PAD_X_L      = DEF_PAD_X_L,
   parameter int unsigned PAD_X_R      = DEF_PAD_X_R,
   parameter int unsigned PAD_SPD      = DEF_PAD_SPD,
   parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int unsigned POINT_FRAMES = DEF_POINT_FRAMES,
   parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE
) (
   input  logic       clk_25,
   input  logic       rst_n,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       btn_start,
   output logic [9:0] bx,
   output logic [9:0] by,
   output logic [9:0] pad_l_y,
   output logic [9:0] pad_r_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [2:0] state,
   output logic       frame_tick
);

   localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES
                                                                      : POINT_FRAMES;
   localparam int unsigned CW = $clog2(MAX_FRAMES + 1);

   localparam logic [9:0]  BX_C  = 10'((XRES - BALL_SIZE) / 2);
   localparam logic [9:0]  BY_C  = 10'((YRES - BALL_SIZE) / 2);
   localparam logic [9:0]  STEP  = 10'(BALL_SPD);
   localparam logic [10:0] SPD_W = 11'(BALL_SPD);
   localparam logic [10:0] BS_W  = 11'(BALL_SIZE);
   localparam logic [10:0] PH_W  = 11'(PAD_H);
   localparam logic [10:0] Y_BOT = 11'(YRES - BALL_SIZE - BALL_SPD);
   localparam logic [10:0] X_RGT = 11'(XRES - BALL_SIZE - BALL_SPD);
   localparam logic [10:0] HIT_L = 11'(PAD_X_L + PAD_W);
   localparam logic [10:0] HIT_R = 11'(PAD_X_R);
   localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

   state_e          st_q;
   logic [CW-1:0]   cnt_q;
   logic            dx_q;       // 1 = moving left
   logic            dy_q;       // 1 = moving up
   logic            serve_dir_q;
   logic            start_q;

   logic            tick;
   logic            start_rise;
   logic            pad_en;
   logic [10:0]     bx_w, by_w, pl_w, pr_w;
   logic            ovl, ovr, hit_l, hit_r, miss_l, miss_r;
   logic            dx_nx, dy_nx;
   logic [9:0]      bx_nx, by_nx;

   assign tick       = (sy == 10'(YMAX)) && (sx == 10'd0);
   assign start_rise = btn_start && !start_q;
   assign pad_en     = tick && (st_q inside {StServe, StPlay, StPoint});
   assign state      = st_q;

   pong_paddle #(
      .YRES    (YRES),
      .PAD_H   (PAD_H),
      .PAD_SPD (PAD_SPD)
   ) u_pad_l (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .en     (pad_en),
      .up     (btn_l_up),
      .dn     (btn_l_dn),
      .y      (pad_l_y)
   );

   pong_paddle #(
      .YRES    (YRES),
      .PAD_H   (PAD_H),
      .PAD_SPD (PAD_SPD)
   ) u_pad_r (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .en     (pad_en),
      .up     (btn_r_up),
      .dn     (btn_r_dn),
      .y      (pad_r_y)
   );

   // Ball next-frame step from the current positions; paddles are pre-update.
   always_comb begin
      bx_w   = {1'b0, bx};
      by_w   = {1'b0, by};
      pl_w   = {1'b0, pad_l_y};
      pr_w   = {1'b0, pad_r_y};
      ovl    = (by_w + BS_W >= pl_w) && (by_w <= pl_w + PH_W);
      ovr    = (by_w + BS_W >= pr_w) && (by_w <= pr_w + PH_W);
      hit_l  = dx_q && (bx_w <= HIT_L) && ovl;
      hit_r  = !dx_q && (bx_w + BS_W >= HIT_R) && ovr;
      miss_l = dx_q && !hit_l && (bx_w < SPD_W);
      miss_r = !dx_q && !hit_r && (bx_w >= X_RGT);
      dx_nx  = hit_l ? 1'b0 : (hit_r ? 1'b1 : dx_q);
      if (by_w < SPD_W) begin
         dy_nx = 1'b0;
      end else if (by_w >= Y_BOT) begin
         dy_nx = 1'b1;
      end else begin
         dy_nx = dy_q;
      end
      bx_nx = dx_nx ? bx - STEP : bx + STEP;
      by_nx = dy_nx ? by - STEP : by + STEP;
   end

   // Match FSM with ball, scores, frame counter and registered tick strobe.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= StIdle;
         cnt_q       <= '0;
         bx          <= BX_C;
         by          <= BY_C;
         dx_q        <= 1'b0;
         dy_q        <= 1'b0;
         serve_dir_q <= 1'b0;
         score_l     <= 4'd0;
         score_r     <= 4'd0;
         start_q     <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         start_q    <= btn_start;
         frame_tick <= tick;
         unique case (st_q)
            StIdle: begin
               if (start_rise) begin
                  st_q  <= StServe;
                  cnt_q <= '0;
                  bx    <= BX_C;
                  by    <= BY_C;
                  dx_q  <= serve_dir_q;
                  dy_q  <= 1'b0;
               end
            end
            StServe: begin
               if (tick) begin
                  if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                     st_q  <= StPlay;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            StPlay: begin
               if (tick) begin
                  if (miss_l) begin
                     score_r     <= sat_inc(score_r);
                     serve_dir_q <= 1'b1;
                     st_q        <= StPoint;
                     cnt_q       <= '0;
                  end else if (miss_r) begin
                     score_l     <= sat_inc(score_l);
                     serve_dir_q <= 1'b0;
                     st_q        <= StPoint;
                     cnt_q       <= '0;
                  end else begin
                     bx   <= bx_nx;
                     by   <= by_nx;
                     dx_q <= dx_nx;
                     dy_q <= dy_nx;
                  end
               end
            end
            StPoint: begin
               if (tick) begin
                  if (cnt_q == CW'(POINT_FRAMES - 1)) begin
                     cnt_q <= '0;
                     if ((score_l == WIN) || (score_r == WIN)) begin
                        st_q <= StOver;
                     end else begin
                        st_q <= StServe;
                        bx   <= BX_C;
                        by   <= BY_C;
                        dx_q <= serve_dir_q;
                        dy_q <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            StOver: begin
               if (start_rise) begin
                  score_l     <= 4'd0;
                  score_r     <= 4'd0;
                  serve_dir_q <= 1'b0;
                  st_q        <= StServe;
                  cnt_q       <= '0;
                  bx          <= BX_C;
                  by          <= BY_C;
                  dx_q        <= 1'b0;
                  dy_q        <= 1'b0;
               end
            end
            default: begin
               st_q <= StIdle;
            end
         endcase
      end
   end

endmodule
